mipi_csi_tx_packet_encoder_8b4lane: RTL and testbench

MIPI_CSI_TX_PACKET_ENCODER_8B4LANE -- requirements
Module: mipi_csi_tx_packet_encoder_8b4lane

---
 rtl/mipi_csi_tx_pkg.sv | 47 ++++
 rtl/mipi_csi_tx_crc16_4byte.sv | 46 ++++
 rtl/mipi_csi_tx_packet_encoder_8b4lane.sv | 210 +++++++++++++++++++++
 tb/tb_mipi_csi_tx_packet_encoder_8b4lane.sv | 466 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mipi_csi_tx_pkg.sv
// ---------------------------------------------------------------------------
// mipi_csi_tx_pkg
// Shared definitions for the CSI-2 transmit packet encoder: the encoder
// state enum, sync byte, short/long data-type threshold, CRC-16 constants
// and the 6-bit packet header ECC function.
// No ports (package).
// ---------------------------------------------------------------------------
package mipi_csi_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    HEADER,
    PAYLOAD,
    FOOTER,
    GAP
  } state_e;

  localparam logic [7:0]  SYNC_BYTE      = 8'hB8;
  localparam logic [5:0]  SHORT_DT_LIMIT = 6'h10;

  // x^16+x^12+x^5+1 in bit-reflected form, because the CRC is shifted LSB first
  localparam logic [15:0] CRC_POLY       = 16'h8408;
  localparam logic [15:0] CRC_INIT       = 16'hFFFF;

  // Each parity bit is the XOR of the header bits selected by its mask
  localparam logic [23:0] ECC_MASK_P0 = 24'hF12CB7;
  localparam logic [23:0] ECC_MASK_P1 = 24'hF2555B;
  localparam logic [23:0] ECC_MASK_P2 = 24'h749A6D;
  localparam logic [23:0] ECC_MASK_P3 = 24'hB8E38E;
  localparam logic [23:0] ECC_MASK_P4 = 24'hDF03F0;
  localparam logic [23:0] ECC_MASK_P5 = 24'hEFFC00;

  // Header ECC over {WC, DI}; the two top bits are always zero
  function automatic logic [7:0] ecc24(input logic [23:0] d);
    logic [7:0] e;
    e    = 8'h00;
    e[0] = ^(d & ECC_MASK_P0);
    e[1] = ^(d & ECC_MASK_P1);
    e[2] = ^(d & ECC_MASK_P2);
    e[3] = ^(d & ECC_MASK_P3);
    e[4] = ^(d & ECC_MASK_P4);
    e[5] = ^(d & ECC_MASK_P5);
    return e;
  endfunction

endpackage

// File: rtl/mipi_csi_tx_crc16_4byte.sv
// ---------------------------------------------------------------------------
// mipi_csi_tx_crc16_4byte
// Running CSI-2 payload CRC-16, absorbing four payload bytes per cycle in
// lane order 0..3, each byte LSB first.
//   clk_i     in   clock, rising edge
//   clear_i   in   synchronous load of the initial value (wins over enable)
//   enable_i  in   absorb data_i this cycle
//   data_i    in   32-bit payload word, lane 0 = [7:0]
//   crc_o     out  current CRC register
// ---------------------------------------------------------------------------
module mipi_csi_tx_crc16_4byte
  import mipi_csi_tx_pkg::*;
(
  input  logic        clk_i,
  input  logic        clear_i,
  input  logic        enable_i,
  input  logic [31:0] data_i,
  output logic [15:0] crc_o
);

  logic [15:0] crc_q;
  logic [15:0] crc_d;

  // Walking data bits 0..31 in order is exactly lane 0..3, LSB first
  always_comb begin
    crc_d = crc_q;
    for (int i = 0; i < 32; i++) begin
      if (crc_d[0] ^ data_i[i]) begin
        crc_d = (crc_d >> 1) ^ CRC_POLY;
      end else begin
        crc_d = crc_d >> 1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      crc_q <= CRC_INIT;
    end else if (enable_i) begin
      crc_q <= crc_d;
    end
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/mipi_csi_tx_packet_encoder_8b4lane.sv
// ---------------------------------------------------------------------------
// mipi_csi_tx_packet_encoder_8b4lane
// Builds CSI-2 packets for a 4-lane, 8-bit-per-lane PHY: sync word, header
// with ECC, payload words streamed at one word per cycle, CRC footer, then a
// forced idle gap. All outputs come straight from registers.
//   clk_i, reset_i         clock, synchronous active-high reset
//   start_i                packet request, honoured only while ready_o=1
//   virtual_channel_i      VC -> DI[7:6]
//   data_type_i            DT -> DI[5:0]; below 6'h10 is a short packet
//   word_count_i           long payload byte count / short packet data field
//   data_i, data_valid_i   payload word and its valid flag
//   ready_o                idle, start_i accepted
//   data_ready_o           payload word requested this cycle
//   data_o, output_valid_o lane bytes and HS burst active
//   lane_valid_o           per-lane byte valid
//   underrun_o             pulse: a payload slot had no data
//   error_o                pulse: a request was rejected
// ---------------------------------------------------------------------------
module mipi_csi_tx_packet_encoder_8b4lane
  import mipi_csi_tx_pkg::*;
#(
  parameter int GAP_CYCLES = 4
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic [1:0]  virtual_channel_i,
  input  logic [5:0]  data_type_i,
  input  logic [15:0] word_count_i,
  input  logic [31:0] data_i,
  input  logic        data_valid_i,
  output logic        ready_o,
  output logic        data_ready_o,
  output logic [31:0] data_o,
  output logic        output_valid_o,
  output logic [3:0]  lane_valid_o,
  output logic        underrun_o,
  output logic        error_o
);

  state_e      state_q, state_d;
  logic [23:0] hdr_q, hdr_d;
  logic        isShort_q, isShort_d;
  logic [13:0] wordsLeft_q, wordsLeft_d;
  logic [7:0]  gapCnt_q, gapCnt_d;

  logic        ready_q, ready_d;
  logic        dataReady_q, dataReady_d;
  logic [31:0] data_q, data_d;
  logic        outValid_q, outValid_d;
  logic [3:0]  laneValid_q, laneValid_d;
  logic        underrun_q, underrun_d;
  logic        error_q, error_d;

  logic [31:0] payloadWord;
  logic [15:0] crc;
  logic        crcClear;
  logic        enterPayload, enterFooter, enterGap;

  // A missing word is replaced by zeros, both on the lanes and in the CRC
  assign payloadWord = data_valid_i ? data_i : 32'h0000_0000;
  assign crcClear    = reset_i || (state_q == IDLE);

  mipi_csi_tx_crc16_4byte u_crc (
    .clk_i    (clk_i),
    .clear_i  (crcClear),
    .enable_i (dataReady_q),
    .data_i   (payloadWord),
    .crc_o    (crc)
  );

  // Next state plus the output values that belong to that next state, so the
  // registered outputs always line up with the registered state.
  // wordsLeft_q counts payload slots still to come after the current cycle.
  always_comb begin
    state_d      = state_q;
    hdr_d        = hdr_q;
    isShort_d    = isShort_q;
    wordsLeft_d  = wordsLeft_q;
    gapCnt_d     = gapCnt_q;
    ready_d      = 1'b0;
    dataReady_d  = 1'b0;
    data_d       = 32'h0000_0000;
    outValid_d   = 1'b0;
    laneValid_d  = 4'h0;
    underrun_d   = 1'b0;
    error_d      = 1'b0;
    enterPayload = 1'b0;
    enterFooter  = 1'b0;
    enterGap     = 1'b0;

    unique case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (start_i) begin
          if ((data_type_i >= SHORT_DT_LIMIT) && (word_count_i[1:0] != 2'b00)) begin
            error_d = 1'b1;
          end else begin
            state_d     = SYNC;
            hdr_d       = {word_count_i, virtual_channel_i, data_type_i};
            isShort_d   = (data_type_i < SHORT_DT_LIMIT);
            wordsLeft_d = word_count_i[15:2];
            ready_d     = 1'b0;
            data_d      = {4{SYNC_BYTE}};
            outValid_d  = 1'b1;
            laneValid_d = 4'hF;
          end
        end
      end
      SYNC: begin
        state_d     = HEADER;
        data_d      = {ecc24(hdr_q), hdr_q};
        outValid_d  = 1'b1;
        laneValid_d = 4'hF;
        dataReady_d = !isShort_q && (wordsLeft_q != 14'd0);
      end
      HEADER: begin
        if (isShort_q) begin
          enterGap = 1'b1;
        end else if (wordsLeft_q == 14'd0) begin
          enterFooter = 1'b1;
        end else begin
          enterPayload = 1'b1;
        end
      end
      PAYLOAD: begin
        if (wordsLeft_q == 14'd0) begin
          enterFooter = 1'b1;
        end else begin
          enterPayload = 1'b1;
        end
      end
      FOOTER: begin
        enterGap = 1'b1;
      end
      GAP: begin
        if (gapCnt_q == 8'd0) begin
          state_d = IDLE;
          ready_d = 1'b1;
        end else begin
          gapCnt_d = gapCnt_q - 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
    endcase

    if (enterPayload) begin
      state_d     = PAYLOAD;
      data_d      = payloadWord;
      underrun_d  = !data_valid_i;
      outValid_d  = 1'b1;
      laneValid_d = 4'hF;
      wordsLeft_d = wordsLeft_q - 14'd1;
      dataReady_d = (wordsLeft_q != 14'd1);
    end
    if (enterFooter) begin
      state_d     = FOOTER;
      data_d      = {16'h0000, crc};
      outValid_d  = 1'b1;
      laneValid_d = 4'b0011;
    end
    if (enterGap) begin
      state_d  = GAP;
      gapCnt_d = 8'(GAP_CYCLES - 1);
    end
  end

  // State, latched header fields, counters and every output register
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      hdr_q       <= 24'h000000;
      isShort_q   <= 1'b0;
      wordsLeft_q <= 14'd0;
      gapCnt_q    <= 8'd0;
      ready_q     <= 1'b1;
      dataReady_q <= 1'b0;
      data_q      <= 32'h0000_0000;
      outValid_q  <= 1'b0;
      laneValid_q <= 4'h0;
      underrun_q  <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      hdr_q       <= hdr_d;
      isShort_q   <= isShort_d;
      wordsLeft_q <= wordsLeft_d;
      gapCnt_q    <= gapCnt_d;
      ready_q     <= ready_d;
      dataReady_q <= dataReady_d;
      data_q      <= data_d;
      outValid_q  <= outValid_d;
      laneValid_q <= laneValid_d;
      underrun_q  <= underrun_d;
      error_q     <= error_d;
    end
  end

  assign ready_o        = ready_q;
  assign data_ready_o   = dataReady_q;
  assign data_o         = data_q;
  assign output_valid_o = outValid_q;
  assign lane_valid_o   = laneValid_q;
  assign underrun_o     = underrun_q;
  assign error_o        = error_q;

endmodule

// File: tb/tb_mipi_csi_tx_packet_encoder_8b4lane.sv
// ---------------------------------------------------------------------------
// tb_mipi_csi_tx_packet_encoder_8b4lane
// Drives packets into the encoder and compares every output cycle with a
// cycle list built from the packet format: sync, header+ECC, payload words,
// CRC footer, idle gap, back to ready.
// ---------------------------------------------------------------------------
module tb_mipi_csi_tx_packet_encoder_8b4lane;

  localparam int GAP = 4;

  // Syndrome column of each header bit: ECC is the XOR of columns of set bits
  localparam logic [5:0] ECC_COL [24] = '{
    6'h07, 6'h0B, 6'h0D, 6'h0E, 6'h13, 6'h15, 6'h16, 6'h19,
    6'h1A, 6'h1C, 6'h23, 6'h25, 6'h26, 6'h29, 6'h2A, 6'h2C,
    6'h31, 6'h32, 6'h34, 6'h38, 6'h1F, 6'h2F, 6'h37, 6'h3B
  };

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        start_i;
  logic [1:0]  virtual_channel_i;
  logic [5:0]  data_type_i;
  logic [15:0] word_count_i;
  logic [31:0] data_i;
  logic        data_valid_i;
  logic        ready_o;
  logic        data_ready_o;
  logic [31:0] data_o;
  logic        output_valid_o;
  logic [3:0]  lane_valid_o;
  logic        underrun_o;
  logic        error_o;

  int          errors = 0;
  int          checks = 0;

  logic [31:0] payloadQ[$];
  bit          validQ[$];
  logic [37:0] obsQ[$];
  logic [37:0] expQ[$];
  int          obsUnderruns;
  int          obsErrors;
  int          obsDrCycles;
  bit          timedOut;

  always #5 clk_i = ~clk_i;

  mipi_csi_tx_packet_encoder_8b4lane #(.GAP_CYCLES(GAP)) dut (
    .clk_i             (clk_i),
    .reset_i           (reset_i),
    .start_i           (start_i),
    .virtual_channel_i (virtual_channel_i),
    .data_type_i       (data_type_i),
    .word_count_i      (word_count_i),
    .data_i            (data_i),
    .data_valid_i      (data_valid_i),
    .ready_o           (ready_o),
    .data_ready_o      (data_ready_o),
    .data_o            (data_o),
    .output_valid_o    (output_valid_o),
    .lane_valid_o      (lane_valid_o),
    .underrun_o        (underrun_o),
    .error_o           (error_o)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [7:0] modelEcc(input logic [23:0] d);
    logic [7:0] e = 8'h00;
    for (int i = 0; i < 24; i++) begin
      if (d[i]) e[5:0] = e[5:0] ^ ECC_COL[i];
    end
    return e;
  endfunction

  // Byte-at-a-time reflected CRC-16/CCITT, init FFFF, no final inversion
  function automatic logic [15:0] modelCrcByte(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r = c ^ {8'h00, b};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 16'h8408) : (r >> 1);
    end
    return r;
  endfunction

  // Expected cycles from the one after the start edge up to the first ready cycle
  task automatic buildExpected(input logic [1:0] vc, input logic [5:0] dt, input logic [15:0] wc);
    logic [23:0] hdr;
    logic [15:0] crc;
    logic [31:0] w;
    expQ.delete();
    hdr = {wc, vc, dt};
    expQ.push_back({32'hB8B8B8B8, 1'b1, 4'hF, 1'b0});
    expQ.push_back({modelEcc(hdr), hdr, 1'b1, 4'hF, 1'b0});
    if (dt >= 6'h10) begin
      crc = 16'hFFFF;
      for (int i = 0; i < int'(wc) / 4; i++) begin
        w = validQ[i] ? payloadQ[i] : 32'h0;
        expQ.push_back({w, 1'b1, 4'hF, 1'b0});
        for (int b = 0; b < 4; b++) crc = modelCrcByte(crc, w[8*b +: 8]);
      end
      expQ.push_back({16'h0000, crc, 1'b1, 4'b0011, 1'b0});
    end
    for (int g = 0; g < GAP; g++) expQ.push_back(38'h0);
    expQ.push_back({32'h0, 1'b0, 4'h0, 1'b1});
  endtask

  task automatic fillPayload(input int n, input int validPct);
    payloadQ.delete();
    validQ.delete();
    for (int i = 0; i < n; i++) begin
      payloadQ.push_back($urandom);
      validQ.push_back($urandom_range(0, 99) < validPct);
    end
  endtask

  task automatic recordCycle();
    obsQ.push_back({data_o, output_valid_o, lane_valid_o, ready_o});
    if (underrun_o === 1'b1) obsUnderruns++;
    if (error_o === 1'b1) obsErrors++;
    if (data_ready_o === 1'b1) obsDrCycles++;
  endtask

  // Sends one packet, feeding payloadQ/validQ whenever the encoder asks for a word
  task automatic applyStimulus(input logic [1:0] vc, input logic [5:0] dt,
                               input logic [15:0] wc, input bit holdStart);
    int k = 0;
    int budget;
    bit done = 0;
    obsQ.delete();
    obsUnderruns = 0;
    obsErrors    = 0;
    obsDrCycles  = 0;
    budget = int'(wc) / 4 + GAP + 20;
    virtual_channel_i = vc;
    data_type_i       = dt;
    word_count_i      = wc;
    start_i           = 1'b1;
    tick();
    if (!holdStart) start_i = 1'b0;
    recordCycle();
    for (int c = 0; c < budget && !done; c++) begin
      if (ready_o === 1'b1) begin
        done = 1;
      end else begin
        if (holdStart) begin
          data_type_i  = 6'h2B;
          word_count_i = 16'($urandom) | 16'h0002;
        end
        if (data_ready_o === 1'b1 && k < payloadQ.size()) begin
          data_valid_i = validQ[k];
          data_i       = validQ[k] ? payloadQ[k] : $urandom;
          k++;
        end else begin
          data_valid_i = 1'b0;
          data_i       = $urandom;
        end
        tick();
        recordCycle();
      end
    end
    if (ready_o === 1'b1) done = 1;
    timedOut     = !done;
    start_i      = 1'b0;
    data_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    tick();
    tick();
    checks += 7;
    if (ready_o !== 1'b1)        begin errors++; $display("[TB] FAIL reset ready_o: got %b want 1", ready_o); end
    if (data_ready_o !== 1'b0)   begin errors++; $display("[TB] FAIL reset data_ready_o: got %b want 0", data_ready_o); end
    if (data_o !== 32'h0)        begin errors++; $display("[TB] FAIL reset data_o: got %h want 0", data_o); end
    if (output_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL reset output_valid_o: got %b want 0", output_valid_o); end
    if (lane_valid_o !== 4'h0)   begin errors++; $display("[TB] FAIL reset lane_valid_o: got %h want 0", lane_valid_o); end
    if (underrun_o !== 1'b0)     begin errors++; $display("[TB] FAIL reset underrun_o: got %b want 0", underrun_o); end
    if (error_o !== 1'b0)        begin errors++; $display("[TB] FAIL reset error_o: got %b want 0", error_o); end
    reset_i = 1'b0;
    tick();
  endtask

  task automatic test_short_fs();
    fillPayload(0, 100);
    applyStimulus(2'd0, 6'h00, 16'h0000, 1'b0);
    buildExpected(2'd0, 6'h00, 16'h0000);
    checks += 3;
    if (obsQ.size() < 2 || obsQ[0][37:6] !== 32'hB8B8B8B8 || obsQ[1][37:6] !== 32'h00000000) begin
      errors++;
      $display("[TB] FAIL short_fs sync/header: got %h %h want b8b8b8b8 00000000",
               obsQ.size() > 0 ? obsQ[0][37:6] : 32'hx, obsQ.size() > 1 ? obsQ[1][37:6] : 32'hx);
    end
    if (timedOut || obsQ.size() != expQ.size()) begin
      errors++;
      $display("[TB] FAIL short_fs length: got %0d cycles want %0d (timeout=%0d)", obsQ.size(), expQ.size(), timedOut);
    end
    if (obsDrCycles != 0) begin errors++; $display("[TB] FAIL short_fs data_ready cycles: got %0d want 0", obsDrCycles); end
    for (int i = 0; i < obsQ.size() && i < expQ.size(); i++) begin
      checks++;
      if (obsQ[i] !== expQ[i]) begin errors++; $display("[TB] FAIL short_fs cycle %0d: got %h want %h", i, obsQ[i], expQ[i]); end
    end
  endtask

  task automatic test_long_vector();
    payloadQ = '{32'h020000FF, 32'h72F3DCB9, 32'h5AB8D4BB, 32'h7CC275C8, 32'hDF05F881, 32'h010000FF};
    validQ   = '{1, 1, 1, 1, 1, 1};
    applyStimulus(2'd0, 6'h2B, 16'd24, 1'b0);
    buildExpected(2'd0, 6'h2B, 16'd24);
    checks += 3;
    if (obsQ.size() < 9 || obsQ[8][37:1] !== {32'h000000F0, 1'b1, 4'b0011}) begin
      errors++;
      $display("[TB] FAIL long_vector footer: got %h want data 000000f0 valid 1 lanes 3",
               obsQ.size() > 8 ? obsQ[8][37:1] : 37'hx);
    end
    if (timedOut || obsQ.size() != expQ.size()) begin
      errors++;
      $display("[TB] FAIL long_vector length: got %0d cycles want %0d (timeout=%0d)", obsQ.size(), expQ.size(), timedOut);
    end
    if (obsDrCycles != 6) begin errors++; $display("[TB] FAIL long_vector data_ready cycles: got %0d want 6", obsDrCycles); end
    for (int i = 0; i < obsQ.size() && i < expQ.size(); i++) begin
      checks++;
      if (obsQ[i] !== expQ[i]) begin errors++; $display("[TB] FAIL long_vector cycle %0d: got %h want %h", i, obsQ[i], expQ[i]); end
    end
  endtask

  task automatic test_ecc_vector();
    fillPayload(124, 100);
    applyStimulus(2'd0, 6'h37, 16'h01F0, 1'b0);
    buildExpected(2'd0, 6'h37, 16'h01F0);
    checks += 2;
    if (obsQ.size() < 2 || obsQ[1][37:6] !== 32'h3F01F037) begin
      errors++;
      $display("[TB] FAIL ecc_vector header: got %h want 3f01f037", obsQ.size() > 1 ? obsQ[1][37:6] : 32'hx);
    end
    if (timedOut || obsQ.size() != expQ.size()) begin
      errors++;
      $display("[TB] FAIL ecc_vector length: got %0d cycles want %0d (timeout=%0d)", obsQ.size(), expQ.size(), timedOut);
    end
    for (int i = 0; i < obsQ.size() && i < expQ.size(); i++) begin
      checks++;
      if (obsQ[i] !== expQ[i]) begin errors++; $display("[TB] FAIL ecc_vector cycle %0d: got %h want %h", i, obsQ[i], expQ[i]); end
    end
  endtask

  task automatic test_long_wc0();
    fillPayload(0, 100);
    applyStimulus(2'd1, 6'h2B, 16'h0000, 1'b0);
    buildExpected(2'd1, 6'h2B, 16'h0000);
    checks += 2;
    if (obsQ.size() < 3 || obsQ[2][37:1] !== {32'h0000FFFF, 1'b1, 4'b0011}) begin
      errors++;
      $display("[TB] FAIL long_wc0 footer: got %h want data 0000ffff valid 1 lanes 3",
               obsQ.size() > 2 ? obsQ[2][37:1] : 37'hx);
    end
    if (timedOut || obsQ.size() != expQ.size()) begin
      errors++;
      $display("[TB] FAIL long_wc0 length: got %0d cycles want %0d (timeout=%0d)", obsQ.size(), expQ.size(), timedOut);
    end
    for (int i = 0; i < obsQ.size() && i < expQ.size(); i++) begin
      checks++;
      if (obsQ[i] !== expQ[i]) begin errors++; $display("[TB] FAIL long_wc0 cycle %0d: got %h want %h", i, obsQ[i], expQ[i]); end
    end
  endtask

  task automatic test_reject();
    virtual_channel_i = 2'd0;
    data_type_i       = 6'h2B;
    word_count_i      = 16'h0A06;
    start_i           = 1'b1;
    tick();
    start_i = 1'b0;
    checks += 3;
    if (error_o !== 1'b1)        begin errors++; $display("[TB] FAIL reject error_o: got %b want 1", error_o); end
    if (ready_o !== 1'b1)        begin errors++; $display("[TB] FAIL reject ready_o: got %b want 1", ready_o); end
    if (output_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL reject output_valid_o: got %b want 0", output_valid_o); end
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (error_o !== 1'b0 || output_valid_o !== 1'b0 || ready_o !== 1'b1) begin
        errors++;
        $display("[TB] FAIL reject after %0d: got err=%b valid=%b ready=%b want 0 0 1", c, error_o, output_valid_o, ready_o);
      end
    end
  endtask

  task automatic test_underrun();
    fillPayload(4, 100);
    validQ[1] = 0;
    applyStimulus(2'd2, 6'h1E, 16'd16, 1'b0);
    buildExpected(2'd2, 6'h1E, 16'd16);
    checks += 3;
    if (obsQ.size() < 4 || obsQ[3][37:6] !== 32'h0) begin
      errors++;
      $display("[TB] FAIL underrun zero word: got %h want 00000000", obsQ.size() > 3 ? obsQ[3][37:6] : 32'hx);
    end
    if (obsUnderruns != 1) begin errors++; $display("[TB] FAIL underrun pulses: got %0d want 1", obsUnderruns); end
    if (timedOut || obsQ.size() != expQ.size()) begin
      errors++;
      $display("[TB] FAIL underrun length: got %0d cycles want %0d (timeout=%0d)", obsQ.size(), expQ.size(), timedOut);
    end
    for (int i = 0; i < obsQ.size() && i < expQ.size(); i++) begin
      checks++;
      if (obsQ[i] !== expQ[i]) begin errors++; $display("[TB] FAIL underrun cycle %0d: got %h want %h", i, obsQ[i], expQ[i]); end
    end
  endtask

  task automatic test_ignore_start();
    fillPayload(3, 100);
    applyStimulus(2'd3, 6'h24, 16'd12, 1'b1);
    buildExpected(2'd3, 6'h24, 16'd12);
    checks += 2;
    if (obsErrors != 0) begin errors++; $display("[TB] FAIL ignore_start error pulses: got %0d want 0", obsErrors); end
    if (timedOut || obsQ.size() != expQ.size()) begin
      errors++;
      $display("[TB] FAIL ignore_start length: got %0d cycles want %0d (timeout=%0d)", obsQ.size(), expQ.size(), timedOut);
    end
    for (int i = 0; i < obsQ.size() && i < expQ.size(); i++) begin
      checks++;
      if (obsQ[i] !== expQ[i]) begin errors++; $display("[TB] FAIL ignore_start cycle %0d: got %h want %h", i, obsQ[i], expQ[i]); end
    end
  endtask

  task automatic test_random();
    logic [1:0]  vc;
    logic [5:0]  dt;
    logic [15:0] wc;
    int          expUnder;
    for (int p = 0; p < 8; p++) begin
      vc = 2'($urandom_range(0, 3));
      expUnder = 0;
      if (p % 2 == 0) begin
        dt = 6'($urandom_range(0, 15));
        wc = 16'($urandom);
        fillPayload(0, 100);
      end else begin
        dt = 6'($urandom_range(16, 63));
        wc = 16'(4 * $urandom_range(0, 16));
        fillPayload(int'(wc) / 4, 85);
        foreach (validQ[i]) if (!validQ[i]) expUnder++;
      end
      applyStimulus(vc, dt, wc, 1'b0);
      buildExpected(vc, dt, wc);
      checks += 2;
      if (obsUnderruns != expUnder) begin
        errors++;
        $display("[TB] FAIL random pkt %0d underruns: got %0d want %0d", p, obsUnderruns, expUnder);
      end
      if (timedOut || obsQ.size() != expQ.size()) begin
        errors++;
        $display("[TB] FAIL random pkt %0d length: got %0d cycles want %0d (timeout=%0d)", p, obsQ.size(), expQ.size(), timedOut);
      end
      for (int i = 0; i < obsQ.size() && i < expQ.size(); i++) begin
        checks++;
        if (obsQ[i] !== expQ[i]) begin
          errors++;
          $display("[TB] FAIL random pkt %0d cycle %0d: got %h want %h", p, i, obsQ[i], expQ[i]);
        end
      end
    end
  endtask

  task automatic test_abort();
    int k = 0;
    fillPayload(16, 100);
    virtual_channel_i = 2'd0;
    data_type_i       = 6'h2B;
    word_count_i      = 16'd64;
    start_i           = 1'b1;
    tick();
    start_i = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (data_ready_o === 1'b1) begin
        data_valid_i = 1'b1;
        data_i       = payloadQ[k];
        k++;
      end else begin
        data_valid_i = 1'b0;
      end
      tick();
    end
    checks++;
    if (output_valid_o !== 1'b1 || data_o !== payloadQ[2]) begin
      errors++;
      $display("[TB] FAIL abort 3rd slot: got valid=%b data=%h want 1 %h", output_valid_o, data_o, payloadQ[2]);
    end
    reset_i      = 1'b1;
    data_valid_i = 1'b1;
    data_i       = payloadQ[3];
    tick();
    reset_i      = 1'b0;
    data_valid_i = 1'b0;
    checks += 2;
    if (output_valid_o !== 1'b0 || ready_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL abort state: got valid=%b ready=%b want 0 1", output_valid_o, ready_o);
    end
    if (data_ready_o !== 1'b0 || data_o !== 32'h0 || lane_valid_o !== 4'h0) begin
      errors++;
      $display("[TB] FAIL abort outputs: got dr=%b data=%h lanes=%h want 0 0 0", data_ready_o, data_o, lane_valid_o);
    end
    fillPayload(0, 100);
    applyStimulus(2'd0, 6'h2B, 16'h0000, 1'b0);
    buildExpected(2'd0, 6'h2B, 16'h0000);
    checks += 2;
    if (obsQ.size() < 3 || obsQ[2][37:6] !== 32'h0000FFFF) begin
      errors++;
      $display("[TB] FAIL abort follow-up footer: got %h want 0000ffff", obsQ.size() > 2 ? obsQ[2][37:6] : 32'hx);
    end
    if (timedOut || obsQ.size() != expQ.size()) begin
      errors++;
      $display("[TB] FAIL abort follow-up length: got %0d cycles want %0d (timeout=%0d)", obsQ.size(), expQ.size(), timedOut);
    end
    for (int i = 0; i < obsQ.size() && i < expQ.size(); i++) begin
      checks++;
      if (obsQ[i] !== expQ[i]) begin errors++; $display("[TB] FAIL abort follow-up cycle %0d: got %h want %h", i, obsQ[i], expQ[i]); end
    end
  endtask

  task automatic test_max_wc();
    int bad = 0;
    fillPayload(16383, 100);
    applyStimulus(2'd1, 6'h2A, 16'hFFFC, 1'b0);
    buildExpected(2'd1, 6'h2A, 16'hFFFC);
    checks += 2;
    if (timedOut || obsQ.size() != expQ.size()) begin
      errors++;
      $display("[TB] FAIL max_wc length: got %0d cycles want %0d (timeout=%0d)", obsQ.size(), expQ.size(), timedOut);
    end
    if (obsDrCycles != 16383) begin errors++; $display("[TB] FAIL max_wc data_ready cycles: got %0d want 16383", obsDrCycles); end
    for (int i = 0; i < obsQ.size() && i < expQ.size(); i++) begin
      checks++;
      if (obsQ[i] !== expQ[i]) begin
        errors++;
        bad++;
        if (bad <= 5) $display("[TB] FAIL max_wc cycle %0d: got %h want %h", i, obsQ[i], expQ[i]);
      end
    end
  endtask

  initial begin
    reset_i           = 1'b1;
    start_i           = 1'b0;
    virtual_channel_i = 2'd0;
    data_type_i       = 6'h00;
    word_count_i      = 16'h0000;
    data_i            = 32'h0;
    data_valid_i      = 1'b0;
    test_reset();
    test_short_fs();
    test_long_vector();
    test_ecc_vector();
    test_long_wc0();
    test_reject();
    test_underrun();
    test_ignore_start();
    test_random();
    test_abort();
    test_max_wc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
